// File: rtl/mem_ctrl_if.sv
// Bus bundle for mem_ctrl: fetch port, LSB port and the byte-wide RAM/IO port.
interface mem_ctrl_if;
  logic        rdy;
  logic        jump_wrong;
  logic        ifetch_req;
  logic [31:0] ifetch_addr;
  logic        ifetch_done;
  logic [31:0] ifetch_data;
  logic        lsb_read_signal;
  logic        lsb_write_signal;
  logic [2:0]  lsb_len;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_data;
  logic        lsb_signed;
  logic        mem_load_success;
  logic        mem_store_success;
  logic [31:0] from_mem_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  rdy, jump_wrong, ifetch_req, ifetch_addr,
           lsb_read_signal, lsb_write_signal, lsb_len, lsb_addr, lsb_data, lsb_signed,
           mem_din, io_buffer_full,
    output ifetch_done, ifetch_data, mem_load_success, mem_store_success, from_mem_data,
           mem_dout, mem_a, mem_wr
  );

  modport master (
    output rdy, jump_wrong, ifetch_req, ifetch_addr,
           lsb_read_signal, lsb_write_signal, lsb_len, lsb_addr, lsb_data, lsb_signed,
           mem_din, io_buffer_full,
    input  ifetch_done, ifetch_data, mem_load_success, mem_store_success, from_mem_data,
           mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates fetch vs LSB and sequences one byte-serial
// RAM transaction at a time (little-endian loads with extension, stores with IO stall).
module mem_ctrl (
  input  logic      clk,
  input  logic      rst,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, STORE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        last_lsb_q, last_lsb_d;
  logic        bubble_q, bubble_d;
  logic [31:0] base_q, base_d;
  logic [2:0]  len_q, len_d;
  logic        signed_q, signed_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] result_q, result_d;
  logic        ifetch_done_q, ifetch_done_d;
  logic [31:0] ifetch_data_q, ifetch_data_d;
  logic        load_ok_q, load_ok_d;
  logic        store_ok_q, store_ok_d;
  logic [31:0] load_data_q, load_data_d;

  logic        lsb_req, grant_lsb, block, stall;
  logic [31:0] assembled, extended;

  assign lsb_req   = bus.lsb_read_signal | bus.lsb_write_signal;
  assign grant_lsb = lsb_req & ~(bus.ifetch_req & last_lsb_q);
  // Done cycle and the cycle after it never grant: requesters are still dropping their level.
  assign block     = bubble_q | ifetch_done_q | load_ok_q | store_ok_q;
  assign stall     = (state_q == STORE) && bus.io_buffer_full && (base_q[17:16] == 2'b11);

  // Byte arriving this cycle belongs to the address issued on the previous one.
  always_comb begin
    assembled = result_q;
    case (cnt_q)
      3'd1:    assembled[7:0]   = bus.mem_din;
      3'd2:    assembled[15:8]  = bus.mem_din;
      3'd3:    assembled[23:16] = bus.mem_din;
      3'd4:    assembled[31:24] = bus.mem_din;
      default: ;
    endcase
    extended = assembled;
    case (len_q)
      3'd1:    extended = {{24{signed_q & assembled[7]}}, assembled[7:0]};
      3'd2:    extended = {{16{signed_q & assembled[15]}}, assembled[15:0]};
      default: extended = assembled;
    endcase
  end

  always_comb begin
    bus.mem_a    = '0;
    bus.mem_dout = '0;
    bus.mem_wr   = 1'b0;
    case (state_q)
      FETCH, LOAD: begin
        if (cnt_q < len_q) bus.mem_a = base_q + {29'b0, cnt_q};
      end
      STORE: begin
        if (!stall) begin
          bus.mem_wr = 1'b1;
          bus.mem_a  = base_q + {29'b0, cnt_q};
          case (cnt_q[1:0])
            2'd0:    bus.mem_dout = wdata_q[7:0];
            2'd1:    bus.mem_dout = wdata_q[15:8];
            2'd2:    bus.mem_dout = wdata_q[23:16];
            default: bus.mem_dout = wdata_q[31:24];
          endcase
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_lsb_d    = last_lsb_q;
    base_d        = base_q;
    len_d         = len_q;
    signed_d      = signed_q;
    wdata_d       = wdata_q;
    result_d      = result_q;
    ifetch_done_d = 1'b0;
    ifetch_data_d = ifetch_data_q;
    load_ok_d     = 1'b0;
    store_ok_d    = 1'b0;
    load_data_d   = load_data_q;
    bubble_d      = ifetch_done_q | load_ok_q | store_ok_q;

    case (state_q)
      IDLE: begin
        if (!bus.jump_wrong && !block) begin
          if (grant_lsb) begin
            state_d    = bus.lsb_write_signal ? STORE : LOAD;
            base_d     = bus.lsb_addr;
            len_d      = bus.lsb_len;
            signed_d   = bus.lsb_signed;
            wdata_d    = bus.lsb_data;
            result_d   = '0;
            cnt_d      = '0;
            last_lsb_d = 1'b1;
          end else if (bus.ifetch_req) begin
            state_d    = FETCH;
            base_d     = bus.ifetch_addr;
            len_d      = 3'd4;
            signed_d   = 1'b0;
            result_d   = '0;
            cnt_d      = '0;
            last_lsb_d = 1'b0;
          end
        end
      end
      FETCH, LOAD: begin
        if (bus.jump_wrong) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (cnt_q != 3'd0) result_d = assembled;
          if (cnt_q == len_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (state_q == FETCH) begin
              ifetch_done_d = 1'b1;
              ifetch_data_d = assembled;
            end else begin
              load_ok_d   = 1'b1;
              load_data_d = extended;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      STORE: begin
        if (!stall) begin
          if (cnt_q == len_q - 3'd1) begin
            state_d    = IDLE;
            cnt_d      = '0;
            store_ok_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_lsb_q    <= 1'b0;
      bubble_q      <= 1'b0;
      base_q        <= '0;
      len_q         <= '0;
      signed_q      <= 1'b0;
      wdata_q       <= '0;
      result_q      <= '0;
      ifetch_done_q <= 1'b0;
      ifetch_data_q <= '0;
      load_ok_q     <= 1'b0;
      store_ok_q    <= 1'b0;
      load_data_q   <= '0;
    end else if (bus.rdy) begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_lsb_q    <= last_lsb_d;
      bubble_q      <= bubble_d;
      base_q        <= base_d;
      len_q         <= len_d;
      signed_q      <= signed_d;
      wdata_q       <= wdata_d;
      result_q      <= result_d;
      ifetch_done_q <= ifetch_done_d;
      ifetch_data_q <= ifetch_data_d;
      load_ok_q     <= load_ok_d;
      store_ok_q    <= store_ok_d;
      load_data_q   <= load_data_d;
    end
  end

  assign bus.ifetch_done       = ifetch_done_q;
  assign bus.ifetch_data       = ifetch_data_q;
  assign bus.mem_load_success  = load_ok_q;
  assign bus.mem_store_success = store_ok_q;
  assign bus.from_mem_data     = load_data_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller sitting between the instruction fetcher, the LSB and the single byte-wide RAM/IO port of the CPU. It arbitrates between instruction-fetch and LSB load/store requests and runs one multi-byte transaction at a time. Each transaction is sequenced byte by byte: little-endian assembly and sign extension for loads, byte-serial writes with I/O back-pressure for stores. Wrong-path fetches and loads are squashed on `jump_wrong`; committed stores always complete.

## Interface
- No parameters.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; low freezes all state and outputs
- jump_wrong  in  1  branch mispredict flush
- ifetch_req  in  1  fetch request, level, held until ifetch_done
- ifetch_addr  in  32  fetch address
- ifetch_done  out  1  one-cycle pulse, ifetch_data valid
- ifetch_data  out  32  fetched instruction word
- lsb_read_signal  in  1  load request, level
- lsb_write_signal  in  1  store request, level
- lsb_len  in  3  byte count 1/2/4 (REQUIRE8/16/32)
- lsb_addr  in  32  load/store address
- lsb_data  in  32  store data, low lsb_len bytes used
- lsb_signed  in  1  sign-extend load result
- mem_load_success  out  1  one-cycle pulse, from_mem_data valid
- mem_store_success  out  1  one-cycle pulse, store fully written
- from_mem_data  out  32  load result, extended to 32 bits
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  RAM write enable (1 = write)
- io_buffer_full  in  1  UART buffer full

## Operation
- States: IDLE, FETCH, LOAD, STORE. A byte counter (0..4) and a last_grant flag (FETCH/LSB) are kept.
- RAM read contract: mem_din in cycle c+1 is the byte at mem_a of cycle c.
- Arbitration happens only in IDLE.
  - LSB request = lsb_read_signal | lsb_write_signal. If both read and write are high, write wins.
  - If only one side requests, that side is granted.
  - If both request, LSB is granted unless last_grant==LSB, in which case fetch is granted. This gives round-robin with no starvation.
- FETCH/LOAD:
  - Addresses base+0..base+n-1 are presented on consecutive cycles with mem_wr=0 (n=4 for fetch).
  - Bytes are captured into result[8k+7:8k].
  - After the last byte, the done pulse fires with the data, and the controller returns to IDLE.
- Load extension:
  - lsb_signed && n==1: replicate bit 7.
  - lsb_signed && n==2: replicate bit 15.
  - Otherwise zero-fill.
- STORE:
  - Each cycle drives mem_wr=1, mem_a=base+k, mem_dout=lsb_data[8k+7:8k], for k=0..n-1.
  - After the last byte, mem_store_success pulses and the controller returns to IDLE.
- I/O stall: in STORE, while io_buffer_full && lsb_addr[17:16]==2'b11, drive mem_wr=0, mem_a=0 and hold k.
- Flush:
  - jump_wrong in FETCH or LOAD: next state IDLE, no done pulse, captured bytes discarded.
  - jump_wrong in STORE: ignored.
  - jump_wrong in IDLE: no grant that cycle.
- Post-done bubble: the first IDLE cycle after any done pulse grants nothing. Requesters drop their level one cycle after done, so this prevents a double grant.
- Address arithmetic is 32-bit wrap-around. No alignment checks.

## Timing
- Reset (async) values:
  - state IDLE, counter 0, last_grant=FETCH.
  - All outputs 0: mem_a, mem_dout, mem_wr, ifetch_done, ifetch_data, mem_load_success, mem_store_success, from_mem_data.
- Cycle 0 is the cycle in which a request is sampled in IDLE (grant edge at its end).
- Read of n bytes:
  - Addresses on cycles 1..n.
  - Bytes captured at the ends of cycles 2..n+1.
  - Done pulse plus data in cycle n+2.
  - Word fetch/load: done in cycle 6.
- Store of n bytes:
  - Writes on cycles 1..n.
  - mem_store_success in cycle n+1 (word: cycle 5), plus one cycle per I/O stall cycle.
- Next grant: earliest in cycle done+2.
- Data outputs hold their last value after the done pulse until the next done.
- Idle/flush cycles drive mem_a=0, mem_wr=0.
- rdy=0: no state, counter or output change; the cycle does not count toward latency.
- rst asserted mid-transaction: immediate abort to reset values. Partially written store bytes remain in RAM.

## Test plan
- Fetch: RAM[0x100..0x103]=13,05,00,00, ifetch_req addr 0x100 -> mem_a 0x100..0x103 on cycles 1-4, ifetch_done cycle 6, ifetch_data=0x00000513.
- Signed loads: RAM[0x200]=0x80, lsb_len=1, lsb_signed=1 -> from_mem_data=0xFFFFFF80, mem_load_success cycle 3. Same with lsb_signed=0 -> 0x00000080. Half from 0x200/0x201=0x80,0xFF unsigned -> 0x0000FF80.
- Store word: lsb_write_signal, addr 0x300, data 0xDEADBEEF -> mem_wr=1 cycles 1-4, mem_dout EF,BE,AD,DE at 0x300..0x303, mem_store_success cycle 5.
- Arbitration: ifetch_req and lsb_read_signal both high from reset -> LSB granted first. Both re-requesting -> fetch granted next, one bubble cycle after the LSB done.
- Flush: jump_wrong in cycle 3 of a fetch -> IDLE at cycle 4, no ifetch_done, mem_a=0. jump_wrong during a store -> store completes, mem_store_success on schedule.
- I/O stall: store byte to 0x30000 with io_buffer_full high cycles 1-3 -> mem_wr=0 cycles 1-3, write in cycle 4, mem_store_success cycle 5. Async rst mid-load -> all outputs 0 immediately.
